// File: rtl/execute_muldiv_seq.sv
// execute_muldiv_seq -- iterative RV32M multiply/divide sequencer.
//
// Sits beside the single-cycle ALU in the execute stage. It accepts one
// M-extension op from decode. A multiply runs as a 32-cycle shift-add and a
// divide runs as a 32-cycle restoring divide. Divide-by-zero and signed
// overflow are resolved in one cycle. While the op is in progress the
// sequencer stalls the front of the pipeline. When the op completes it
// presents the result for one cycle, together with the destination register.
//
// Optional feature macro: MULDIV_FAST_MUL_EN
//   When defined, all multiplies use a single 64-bit product operator and
//   complete in one cycle. Divides are unchanged.
//
// Ports
//   clk           core clock; all state changes on the rising edge
//   rst           asynchronous active-high reset
//   start         decode presents a valid M-extension op this cycle
//   op[2:0]       funct3: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
//   rs_data1      operand A (multiplicand / dividend)
//   rs_data2      operand B (multiplier / divisor)
//   decode_rd     destination register of the op
//   flush         abort the current op (redirect)
//   busy          sequencer not idle
//   stall         hold decode/fetch
//   result_valid  one-cycle pulse: result / result_rd valid
//   result        op result (held until the next completion)
//   result_rd     destination register of result (held likewise)
module execute_muldiv_seq #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned ITER = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs_data1,
  input  logic [XLEN-1:0] rs_data2,
  input  logic [4:0]      decode_rd,
  input  logic            flush,
  output logic            busy,
  output logic            stall,
  output logic            result_valid,
  output logic [XLEN-1:0] result,
  output logic [4:0]      result_rd
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [5:0]        cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic [4:0]        rd_q, rd_d;
  logic              neg_ab_q, neg_ab_d;    // product / quotient sign
  logic              neg_a_q, neg_a_d;      // remainder sign
  logic [2*XLEN-1:0] acc_q, acc_d;          // multiply accumulator
  logic [2*XLEN-1:0] mcand_q, mcand_d;      // multiplicand, shifts left
  logic [XLEN-1:0]   mplier_q, mplier_d;    // multiplier, shifts right
  logic [XLEN-1:0]   rem_q, rem_d;          // partial remainder
  logic [XLEN-1:0]   quo_q, quo_d;          // dividend in, quotient out
  logic [XLEN-1:0]   dvsr_q, dvsr_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic [4:0]        result_rd_q, result_rd_d;

  // Operand decode on the incoming op
  logic            a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            div_zero, div_ovf, special, direct;
  logic [XLEN-1:0] direct_res;

  assign a_signed = op[2] ? ~op[0] : (op == 3'b001 || op == 3'b010);
  assign b_signed = op[2] ? ~op[0] : (op == 3'b001);
  assign a_neg    = a_signed & rs_data1[XLEN-1];
  assign b_neg    = b_signed & rs_data2[XLEN-1];
  // A negated 0x80000000 stays 0x80000000, which is the correct unsigned magnitude
  assign a_mag    = a_neg ? (~rs_data1 + 1'b1) : rs_data1;
  assign b_mag    = b_neg ? (~rs_data2 + 1'b1) : rs_data2;

  assign div_zero = (rs_data2 == '0);
  assign div_ovf  = ~op[0] & (rs_data1 == {1'b1, {(XLEN-1){1'b0}}}) & (rs_data2 == '1);
  assign special  = op[2] & (div_zero | div_ovf);

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_prod;
  logic [XLEN-1:0]   fast_res;
  // Both operands are sign/zero-extended to 64 bits. The low 64 bits of the
  // modular product are then the exact signed/unsigned product.
  assign fast_prod = {{XLEN{a_neg}}, rs_data1} * {{XLEN{b_neg}}, rs_data2};
  assign fast_res  = (op[1:0] == 2'b00) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
  assign direct    = special | ~op[2];
`else
  assign direct    = special;
`endif

  always_comb begin
    direct_res = '0;
    if (div_zero)     direct_res = op[1] ? rs_data1 : '1;
    else if (div_ovf) direct_res = op[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
`ifdef MULDIV_FAST_MUL_EN
    if (~op[2])       direct_res = fast_res;
`endif
  end

  // One iteration step; both datapaths advance every CALC cycle
  logic [2*XLEN-1:0] acc_nx, prod_f;
  logic [XLEN:0]     shifted;
  logic              ge;
  logic [XLEN-1:0]   rem_nx, quo_nx, quo_f, rem_f, mul_res, calc_res;

  always_comb begin
    acc_nx  = acc_q + (mplier_q[0] ? mcand_q : '0);
    shifted = {rem_q, quo_q[XLEN-1]};
    ge      = (shifted >= {1'b0, dvsr_q});
    // When ge holds, the true difference is below dvsr, so 32-bit wrap is exact
    rem_nx  = ge ? (shifted[XLEN-1:0] - dvsr_q) : shifted[XLEN-1:0];
    quo_nx  = {quo_q[XLEN-2:0], ge};
    prod_f  = neg_ab_q ? (~acc_nx + 1'b1) : acc_nx;
    quo_f   = neg_ab_q ? (~quo_nx + 1'b1) : quo_nx;
    rem_f   = neg_a_q  ? (~rem_nx + 1'b1) : rem_nx;
    mul_res = (op_q[1:0] == 2'b00) ? prod_f[XLEN-1:0] : prod_f[2*XLEN-1:XLEN];
    if (~op_q[2])   calc_res = mul_res;
    else if (op_q[1]) calc_res = rem_f;
    else            calc_res = quo_f;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    rd_d        = rd_q;
    neg_ab_d    = neg_ab_q;
    neg_a_d     = neg_a_q;
    acc_d       = acc_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvsr_d      = dvsr_q;
    result_d    = result_q;
    result_rd_d = result_rd_q;

    unique case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          op_d     = op;
          rd_d     = decode_rd;
          neg_ab_d = a_neg ^ b_neg;
          neg_a_d  = a_neg;
          acc_d    = '0;
          mcand_d  = {{XLEN{1'b0}}, a_mag};
          mplier_d = b_mag;
          rem_d    = '0;
          quo_d    = a_mag;
          dvsr_d   = b_mag;
          cnt_d    = '0;
          if (direct) begin
            result_d    = direct_res;
            result_rd_d = decode_rd;
            state_d     = S_DONE;
          end else begin
            state_d     = S_CALC;
          end
        end
      end
      S_CALC: begin
        acc_d    = acc_nx;
        mcand_d  = {mcand_q[2*XLEN-2:0], 1'b0};
        mplier_d = {1'b0, mplier_q[XLEN-1:1]};
        rem_d    = rem_nx;
        quo_d    = quo_nx;
        cnt_d    = cnt_q + 6'd1;
        if (cnt_q == 6'(ITER - 1)) begin
          result_d    = calc_res;
          result_rd_d = rd_q;
          state_d     = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // A flush always wins. It also keeps the visible result from being updated.
    if (flush) begin
      state_d     = S_IDLE;
      result_d    = result_q;
      result_rd_d = result_rd_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      op_q        <= '0;
      rd_q        <= '0;
      neg_ab_q    <= 1'b0;
      neg_a_q     <= 1'b0;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvsr_q      <= '0;
      result_q    <= '0;
      result_rd_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      rd_q        <= rd_d;
      neg_ab_q    <= neg_ab_d;
      neg_a_q     <= neg_a_d;
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvsr_q      <= dvsr_d;
      result_q    <= result_d;
      result_rd_q <= result_rd_d;
    end
  end

  assign busy         = (state_q != S_IDLE);
  assign stall        = ((state_q == S_IDLE) & start) | (state_q == S_CALC);
  assign result_valid = (state_q == S_DONE) & ~flush;
  assign result       = result_q;
  assign result_rd    = result_rd_q;

endmodule

// File: tb/tb_execute_muldiv_seq.sv
// Testbench for execute_muldiv_seq: directed and random RV32M ops, checked
// through a result scoreboard against an arithmetic reference model.
module tb_execute_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic [4:0]  rd;
  logic        busy, stall, result_valid;
  logic [31:0] result;
  logic [4:0]  result_rd;

  execute_muldiv_seq #(.XLEN(32), .ITER(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .rs_data1(a), .rs_data2(b), .decode_rd(rd), .flush(flush),
    .busy(busy), .stall(stall), .result_valid(result_valid),
    .result(result), .result_rd(result_rd)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int          cyc;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Reference: plain 64-bit arithmetic on the architectural RV32M rules
  function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, ux, uy, p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = longint'(x);
    uy = longint'(y);
    case (o)
      3'd0: begin p = ux * uy; return p[31:0];  end
      3'd1: begin p = sx * sy; return p[63:32]; end
      3'd2: begin p = sx * uy; return p[63:32]; end
      3'd3: begin p = ux * uy; return p[63:32]; end
      3'd4: begin
        if (y == 0) return 32'hFFFF_FFFF;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = sx / sy; return p[31:0];
      end
      3'd5: begin
        if (y == 0) return 32'hFFFF_FFFF;
        p = ux / uy; return p[31:0];
      end
      3'd6: begin
        if (y == 0) return x;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h0;
        p = sx % sy; return p[31:0];
      end
      default: begin
        if (y == 0) return x;
        p = ux % uy; return p[31:0];
      end
    endcase
  endfunction

  function automatic int lat(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    if (o[2] && (y == 0 || (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF))) return 1;
`ifdef MULDIV_FAST_MUL_EN
    if (!o[2]) return 1;
`endif
    return 33;
  endfunction

  // Monitor: every result pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rst === 1'b0 && result_valid === 1'b1) begin
      if (sbq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_result: got result_valid=1 result=%h rd=%0d, expected no result (cycle %0d)",
                 result, result_rd, cyc);
      end else begin
        mon_e = sbq.pop_front();
        chk("result", result, mon_e.res);
        chk("result_rd", {27'b0, result_rd}, {27'b0, mon_e.rd});
        chk("result_cycle", 32'(cyc), 32'(mon_e.cyc));
      end
    end
  end

  // Called just after a rising edge while the DUT is idle; returns at cycle t+1 (+1ns)
  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [4:0] r, input bit push, output int t);
    exp_t e;
    op = o; a = x; b = y; rd = r; start = 1'b1;
    t = cyc;
    if (push) begin
      e.res = ref_model(o, x, y);
      e.rd  = r;
      e.cyc = cyc + lat(o, x, y);
      sbq.push_back(e);
    end
    @(negedge clk);
    chk("stall_accept", {31'b0, stall}, 32'd1);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic watch_stall(input int l);
    for (int k = 1; k <= l; k++) begin
      @(negedge clk);
      chk("stall_cycle", {31'b0, stall}, {31'b0, (k < l)});
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("idle_timeout", {31'b0, busy}, 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
  endtask

  int t, t2, sel;
  logic [2:0]  ro;
  logic [31:0] rx, ry;

  initial begin
    rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0; rd = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_stall", {31'b0, stall}, 32'd0);
    chk("reset_valid", {31'b0, result_valid}, 32'd0);
    chk("reset_result", result, 32'd0);
    chk("reset_rd", {27'b0, result_rd}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed cases
    wait_idle(); issue(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 1'b1, t); watch_stall(lat(3'd0, 32'd7, 32'hFFFF_FFFD));
    wait_idle(); issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 1'b1, t);
    wait_idle(); issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 1'b1, t);
    wait_idle(); issue(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd8, 1'b1, t);
    wait_idle(); issue(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd9, 1'b1, t);
    wait_idle(); issue(3'd5, 32'h1234_5678, 32'd0, 5'd10, 1'b1, t); watch_stall(1);
    wait_idle(); issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 1'b1, t); watch_stall(1);
    drain();

    // Flush during CALC, then restart the very next cycle
    wait_idle();
    issue(3'd4, 32'd100, 32'd7, 5'd20, 1'b0, t);
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    chk("flush_busy", {31'b0, busy}, 32'd0);
    chk("flush_valid", {31'b0, result_valid}, 32'd0);
    issue(3'd4, 32'd100, 32'd7, 5'd21, 1'b1, t2);
    drain();

    // A start while busy must be ignored
    wait_idle();
    issue(3'd2, 32'hF000_0003, 32'h0000_0101, 5'd12, 1'b1, t);
    repeat (4) @(posedge clk);
    #1 start = 1'b1; op = 3'd5; a = 32'd99; b = 32'd3; rd = 5'd13;
    @(posedge clk); #1 start = 1'b0;
    drain();
    repeat (40) @(posedge clk);
    #1;

    // Reset in the middle of CALC
    wait_idle();
    issue(3'd6, 32'd1000, 32'd33, 5'd14, 1'b0, t);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst_busy", {31'b0, busy}, 32'd0);
    chk("midrst_stall", {31'b0, stall}, 32'd0);
    chk("midrst_valid", {31'b0, result_valid}, 32'd0);
    chk("midrst_result", result, 32'd0);
    chk("midrst_rd", {27'b0, result_rd}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Random ops with biased special cases
    for (int i = 0; i < 60; i++) begin
      ro  = 3'($urandom_range(0, 7));
      rx  = $urandom;
      ry  = $urandom;
      sel = $urandom_range(0, 9);
      if (sel == 0) ry = '0;
      else if (sel == 1) begin rx = 32'h8000_0000; ry = 32'hFFFF_FFFF; end
      else if (sel == 2) ry = 32'($urandom_range(1, 15));
      else if (sel == 3) ry = -32'($urandom_range(1, 15));
      wait_idle();
      issue(ro, rx, ry, 5'($urandom_range(0, 31)), 1'b1, t);
    end
    drain();
    repeat (5) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/execute_muldiv_seq.md
Name: execute_muldiv_seq

Overview:
- Iterative RV32M multiply/divide sequencer beside the single-cycle ALU in the execute stage.
- Accepts one M-extension op from decode and runs a shift-add multiply or a restoring divide over 32 cycles.
- Stalls the front of the pipeline while busy, then presents a one-cycle result with its destination register for writeback.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- ITER, 32, iterations per normal op; must equal XLEN.

Ports:
- clk  in  1  core clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  decode presents a valid M-extension op this cycle
- op  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- rs_data1  in  32  operand A (dividend / multiplicand)
- rs_data2  in  32  operand B (divisor / multiplier)
- decode_rd  in  5  destination register of the op
- flush  in  1  abort the current op (jump/branch redirect)
- busy  out  1  sequencer not idle
- stall  out  1  hold decode/fetch
- result_valid  out  1  result and result_rd valid, one-cycle pulse
- result  out  32  op result
- result_rd  out  5  destination register of the result

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- On reset: state IDLE, busy=0, stall=0, result_valid=0, result=0, result_rd=0, internal registers cleared.
- States and transitions:
  - IDLE -> CALC when start=1 and op is not a special case; operands, op and rd are latched.
  - IDLE -> DONE when start=1 and op is a special case.
  - CALC holds for exactly ITER cycles, counted by a 6-bit counter, then -> DONE.
  - DONE asserts result_valid for one cycle, then -> IDLE.
- Latency:
  - start sampled at edge t; normal ops give result_valid in cycle t+33.
  - Special cases give result_valid in cycle t+1.
- stall = (IDLE & start) | CALC. It is combinational, so decode holds on the accept cycle. stall is 0 in DONE so the pipeline advances while writeback consumes the result.
- busy = state != IDLE.
- start is ignored unless in IDLE. No queueing.
- Multiply:
  - Operands are converted to magnitudes per op signedness: MULH both signed, MULHSU A signed / B unsigned, MULHU and MUL unsigned.
  - 64-bit shift-add accumulation, one multiplier bit per cycle.
  - The product is negated at DONE if the sign flags differ.
  - MUL returns product[31:0]; the MULH variants return product[63:32].
- Divide:
  - Restoring division on magnitudes (signed for DIV/REM).
  - Quotient sign = sign(A) xor sign(B). Remainder sign = sign(A).
- Special cases, resolved in one cycle:
  - Divisor 0: DIV/DIVU return 0xFFFFFFFF; REM/REMU return A.
  - Signed overflow (A=0x80000000, B=0xFFFFFFFF): DIV returns 0x80000000, REM returns 0.
- flush:
  - In any state, the next state is IDLE and result_valid stays 0. This includes DONE, where the pulse is suppressed if flush is high in that cycle.
  - flush together with start in IDLE: start is ignored.
- Reset mid-operation: immediate return to IDLE; no result is produced.
- result and result_rd hold their last values after DONE and change only on the next DONE.

Optional Feature:
- Macro: MULDIV_FAST_MUL_EN.
- When defined:
  - MUL/MULH/MULHSU/MULHU use a single 64-bit signed-extended product operator.
  - These ops go IDLE -> DONE, so result_valid arrives at t+1 and stall is high only in the accept cycle.
  - Divide is unchanged.
- When undefined: all multiplies take the 32-iteration path at t+33.

Test Plan:
- MUL, A=7, B=0xFFFFFFFD -> result_valid at t+33 (t+1 with MULDIV_FAST_MUL_EN), result=0xFFFFFFEB; stall high t through t+32.
- MULHU, A=B=0xFFFFFFFF -> result=0xFFFFFFFE; MULH with the same operands -> result=0x00000000.
- DIV, A=0xFFFFFFF9 (-7), B=2 -> result=0xFFFFFFFD at t+33; REM with the same operands -> result=0xFFFFFFFF.
- DIVU with B=0 -> result=0xFFFFFFFF at t+1; DIV with A=0x80000000, B=0xFFFFFFFF -> result=0x80000000 at t+1, stall only at t.
- Flush during CALC at cycle t+10 -> no result_valid, busy=0 at t+11; a new start at t+11 is accepted and completes correctly.
- rst asserted mid-CALC -> all outputs 0 immediately; start held during busy is ignored, so a second start at t+5 produces no extra result.
